// File: rtl/jk_counter_pkg.sv
// ---------------------------------------------------------------------------
// jk_counter_pkg
// Purpose : shared definitions for the JK-cell based up/down counter.
//   - JK input encodings used by the excitation logic and the storage cell.
//   - clamp_load(): limits a parallel-load value to the counter's range.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package jk_counter_pkg;

  // {J, K} encodings
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Any load value above the terminal value is replaced by the terminal
  // value, so an out-of-range count can never be stored.
  function automatic int unsigned clamp_load(input int unsigned val,
                                             input int unsigned max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/jk_updown_counter_if.sv
// ---------------------------------------------------------------------------
// jk_updown_counter_if
// Purpose : groups the control inputs and count outputs of jk_updown_counter.
// Signals : en, up_dn, load, load_val[WIDTH] (controls, driven by master)
//           count[WIDTH], count_bar[WIDTH], tc (status, driven by slave)
// Modports: master - the block controlling the counter
//           slave  - the counter itself
// ---------------------------------------------------------------------------
interface jk_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_bar;
  logic             tc;

  modport master (
    output en, up_dn, load, load_val,
    input  count, count_bar, tc
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count, count_bar, tc
  );
endinterface

// File: rtl/jk_updown_counter_cell.sv
// ---------------------------------------------------------------------------
// jk_cell_sync
// Purpose : one JK storage cell with synchronous active-high reset.
// Ports   : clk      - rising-edge clock
//           rst      - synchronous reset, active-high (q=0, q_bar=1)
//           j_i, k_i - JK inputs: 00 hold, 01 reset, 10 set, 11 toggle
//           q_o      - stored bit
//           q_bar_o  - complement of the stored bit
// ---------------------------------------------------------------------------
module jk_cell_sync
  import jk_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j_i,
  input  logic k_i,
  output logic q_o,
  output logic q_bar_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({j_i, k_i})
      JK_HOLD:   q_d = q_q;
      JK_RESET:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  // Q_bar is derived from the single stored bit so it can never disagree
  // with Q.
  assign q_o     = q_q;
  assign q_bar_o = ~q_q;

endmodule

// File: rtl/jk_updown_counter.sv
// ---------------------------------------------------------------------------
// jk_updown_counter
// Purpose : synchronous modulo-(MAX_COUNT+1) up/down counter with parallel
//           load, built from WIDTH JK cells plus excitation logic.
//           Priority per edge: rst > load > en > hold.
// Params  : WIDTH (2..16), MAX_COUNT (<= 2**WIDTH-1)
// Ports   : clk  - rising-edge clock
//           rst  - synchronous reset, active-high (count=0)
//           bus  - jk_updown_counter_if.slave:
//                  en, up_dn, load, load_val -> count, count_bar, tc
// Options : JK_CNT_SATURATE_EN - when defined, counting stops at the bounds
//           (MAX_COUNT going up, 0 going down) instead of wrapping.
// ---------------------------------------------------------------------------
module jk_updown_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  jk_updown_counter_if.slave     bus
);

  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_COUNT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_bar_q;
  logic [WIDTH-1:0] next_d;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;

  assign load_clamped = WIDTH'(clamp_load(32'(bus.load_val), 32'(MAX_COUNT)));

  // One extra bit keeps +1 at 2**WIDTH-1 and -1 at 0 visible.
  assign inc_ext = {1'b0, count_q} + 1'b1;
  assign dec_ext = {1'b0, count_q} - 1'b1;

  always_comb begin
    next_d = count_q;
    if (bus.load) begin
      next_d = load_clamped;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (inc_ext > MAX_EXT) begin
`ifdef JK_CNT_SATURATE_EN
          next_d = MAX_W;
`else
          next_d = '0;
`endif
        end else begin
          next_d = inc_ext[WIDTH-1:0];
        end
      end else begin
        // Top bit set means the decrement borrowed, i.e. count was 0.
        if (dec_ext[WIDTH]) begin
`ifdef JK_CNT_SATURATE_EN
          next_d = '0;
`else
          next_d = MAX_W;
`endif
        end else begin
          next_d = dec_ext[WIDTH-1:0];
        end
      end
    end
  end

  // Excitation: set bits that must rise, reset bits that must fall, hold
  // the rest. Toggle is never requested.
  assign j_d = ~count_q & next_d;
  assign k_d = count_q & ~next_d;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell_sync u_cell (
        .clk     (clk),
        .rst     (rst),
        .j_i     (j_d[gi]),
        .k_i     (k_d[gi]),
        .q_o     (count_q[gi]),
        .q_bar_o (count_bar_q[gi])
      );
    end
  endgenerate

  assign bus.count     = count_q;
  assign bus.count_bar = count_bar_q;
  assign bus.tc        = bus.en & ~bus.load &
                         ((bus.up_dn & (count_q == MAX_W)) |
                          (~bus.up_dn & (count_q == '0)));

endmodule

// File: tb/tb_jk_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_jk_updown_counter
// Directed test-plan sequences followed by random stimulus, checked every
// cycle against a plain-arithmetic model of the counter.
// Build with +define+JK_CNT_SATURATE_EN to exercise the saturating variant.
// ---------------------------------------------------------------------------
module tb_jk_updown_counter;

  localparam int WIDTH     = 4;
  localparam int MAX_COUNT = 9;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;
  int model_cnt = 0;
  int cyc = 0;

  jk_updown_counter_if #(.WIDTH(WIDTH)) bus ();

  jk_updown_counter #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", tag, cyc, actual, expected);
    end
  endtask

  // Reference next value from the counter's rules.
  function automatic int model_next(input int cur, input bit r, input bit e,
                                    input bit ud, input bit l, input int lv);
    if (r) return 0;
    if (l) return (lv > MAX_COUNT) ? MAX_COUNT : lv;
    if (!e) return cur;
`ifdef JK_CNT_SATURATE_EN
    if (ud) return (cur == MAX_COUNT) ? MAX_COUNT : cur + 1;
    return (cur == 0) ? 0 : cur - 1;
`else
    if (ud) return (cur + 1) % (MAX_COUNT + 1);
    return (cur + MAX_COUNT) % (MAX_COUNT + 1);
`endif
  endfunction

  // Called at posedge+1; applies inputs, checks tc mid-cycle, then checks
  // count/count_bar just after the next edge.
  task automatic do_cycle(input bit r, input bit e, input bit ud,
                          input bit l, input int lv);
    bit exp_tc;
    rst          = r;
    bus.en       = e;
    bus.up_dn    = ud;
    bus.load     = l;
    bus.load_val = WIDTH'(lv);
    #1;
    exp_tc = e && !l && ((ud && model_cnt == MAX_COUNT) || (!ud && model_cnt == 0));
    check("tc", 32'(bus.tc), 32'(exp_tc));
    @(posedge clk);
    model_cnt = model_next(model_cnt, r, e, ud, l, lv);
    #1;
    cyc++;
    check("count", 32'(bus.count), 32'(model_cnt));
    check("count_bar", 32'(bus.count_bar), 32'((~model_cnt) & ((1 << WIDTH) - 1)));
    $display("cyc=%0d rst=%0b en=%0b up=%0b load=%0b lv=%0d -> count=%0d tc_before=%0b exp=%0d",
             cyc, r, e, ud, l, lv, bus.count, exp_tc, model_cnt);
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.up_dn = 1'b0;
    bus.load = 1'b0;
    bus.load_val = '0;
    @(posedge clk);
    #1;

    // Reset for two edges
    repeat (2) do_cycle(1, 0, 0, 0, 0);
    // Count up 12 edges: 0..9,0,1 with wrap
    repeat (12) do_cycle(0, 1, 1, 0, 0);
    // Load 5, count down 7 edges through 0 -> 9 -> 8
    do_cycle(0, 0, 0, 1, 5);
    repeat (7) do_cycle(0, 1, 0, 0, 0);
    // Clamped load
    do_cycle(0, 1, 0, 1, 14);
    check("clamp", 32'(bus.count), 32'(MAX_COUNT));
    // Load wins over enable
    do_cycle(0, 1, 1, 1, 3);
    check("load_over_en", 32'(bus.count), 32'd3);
    // Count up to 6, then reset together with a load
    repeat (3) do_cycle(0, 1, 1, 0, 0);
    do_cycle(1, 1, 1, 1, 8);
    check("rst_over_load", 32'(bus.count_bar), 32'hF);
    // Hold
    do_cycle(0, 0, 1, 0, 0);

`ifdef JK_CNT_SATURATE_EN
    do_cycle(0, 0, 0, 1, 8);
    repeat (3) do_cycle(0, 1, 1, 0, 0);
    check("sat_hi", 32'(bus.count), 32'(MAX_COUNT));
    do_cycle(0, 0, 0, 1, 1);
    repeat (3) do_cycle(0, 1, 0, 0, 0);
    check("sat_lo", 32'(bus.count), 32'd0);
`endif

    // Random stimulus
    for (int i = 0; i < 300; i++) begin
      do_cycle(($urandom_range(0, 31) == 0),
               ($urandom_range(0, 3) != 0),
               1'($urandom),
               ($urandom_range(0, 5) == 0),
               int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
